// File: rtl/seg_clock_core.sv
`default_nettype none
// ============================================================================
//  Module      : seg_clock_core
//  Description : Timekeeping and display core for the digital clock.
//                - Keeps hours, minutes and seconds, advanced by a 1 s tick
//                  that is divided down from clk.
//                - Drives a multiplexed, active-low 7-segment display.
//                - Supports 12 h / 24 h display, run/stop control, set-time
//                  pulses and an optional blinking colon.
//                - Optional macro SECONDS_DISP_EN extends the display scan to
//                  eight positions (second colon plus seconds digits).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_clock_core #(
    parameter int TICKS_PER_SEC   = 1000,
    parameter int TICKS_PER_DIGIT = 1,
    parameter int START_HOUR      = 0,
    parameter int COLON_BLINK     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mil_time,
    input  logic       inc_hr,
    input  logic       inc_min,
    output logic [6:0] segment_data,
    output logic [2:0] digit_select,
    output logic       pm,
    output logic       sec_tick,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds
);

    localparam int PRE_W  = $clog2(TICKS_PER_SEC);
    localparam int SCAN_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [PRE_W-1:0]  PRE_HALF   = PRE_W'(TICKS_PER_SEC / 2);
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(TICKS_PER_DIGIT - 1);
    localparam logic [4:0]        RESET_HOUR = 5'(START_HOUR);
    localparam logic [6:0]        SEG_BLANK  = 7'b111_1111;
    localparam logic [6:0]        SEG_COLON  = 7'b111_1001;

`ifdef SECONDS_DISP_EN
    localparam logic [2:0] LAST_POS = 3'd7;
`else
    localparam logic [2:0] LAST_POS = 3'd4;
`endif

    logic [PRE_W-1:0]  prescaler;
    logic [PRE_W-1:0]  prescaler_next;
    logic              tick_next;
    logic [SCAN_W-1:0] scan_cnt;
    logic [SCAN_W-1:0] scan_next;
    logic [2:0]        pos_next;
    logic [5:0]        seconds_next;
    logic [5:0]        minutes_next;
    logic [4:0]        hours_next;
    logic              min_carry;
    logic              hr_carry;
    logic [4:0]        hour_disp;
    logic [3:0]        hour_tens;
    logic [3:0]        hour_ones;
    logic [3:0]        min_tens;
    logic [3:0]        min_ones;
    logic [6:0]        colon_seg;
    logic [6:0]        seg_next;
`ifdef SECONDS_DISP_EN
    logic [3:0]        sec_tens;
    logic [3:0]        sec_ones;
`endif

    // Decimal tens digit of a 0..59 value.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [3:0] t;
        t = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            if (v >= 6'(k * 10)) t = 4'(k);
        end
        return t;
    endfunction

    // Decimal ones digit of a 0..59 value.
    function automatic logic [3:0] ones_of(input logic [5:0] v);
        return 4'(v - (6'(tens_of(v)) * 6'd10));
    endfunction

    // Active-low segment pattern {a,b,c,d,e,f,g} for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b000_0001;
            4'd1:    s = 7'b100_1111;
            4'd2:    s = 7'b001_0010;
            4'd3:    s = 7'b000_0110;
            4'd4:    s = 7'b100_1100;
            4'd5:    s = 7'b010_0100;
            4'd6:    s = 7'b010_0000;
            4'd7:    s = 7'b000_1111;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b000_0100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Prescaler advance and the tick decision for the coming edge.
    always_comb begin
        prescaler_next = prescaler;
        tick_next      = 1'b0;
        if (run) begin
            if (prescaler == PRE_LAST) begin
                prescaler_next = '0;
                tick_next      = 1'b1;
            end else begin
                prescaler_next = prescaler + 1'b1;
            end
        end
    end

    // Next time value: the registered tick advances seconds with carries;
    // a set pulse replaces (never stacks with) a coincident carry.
    always_comb begin
        seconds_next = seconds;
        minutes_next = minutes;
        hours_next   = hours;
        min_carry    = sec_tick && (seconds == 6'd59);
        hr_carry     = min_carry && (minutes == 6'd59) && !inc_min;
        if (sec_tick) begin
            seconds_next = (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
        end
        if (inc_min || min_carry) begin
            minutes_next = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        end
        if (inc_hr || hr_carry) begin
            hours_next = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end
    end

    // Prescaler, tick pulse and time-of-day registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            sec_tick  <= 1'b0;
            seconds   <= 6'd0;
            minutes   <= 6'd0;
            hours     <= RESET_HOUR;
            pm        <= (START_HOUR >= 12);
        end else begin
            prescaler <= prescaler_next;
            sec_tick  <= tick_next;
            seconds   <= seconds_next;
            minutes   <= minutes_next;
            hours     <= hours_next;
            pm        <= (hours_next >= 5'd12);
        end
    end

    // Scan position and segment pattern for the coming edge; built from the
    // next-state values so the registered display matches the registered time.
    always_comb begin
        scan_next = scan_cnt + 1'b1;
        pos_next  = digit_select;
        if (scan_cnt == SCAN_LAST) begin
            scan_next = '0;
            pos_next  = (digit_select == LAST_POS) ? 3'd0 : digit_select + 3'd1;
        end

        hour_disp = hours_next;
        if (!mil_time) begin
            if (hours_next == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hours_next > 5'd12) begin
                hour_disp = hours_next - 5'd12;
            end
        end
        hour_tens = tens_of({1'b0, hour_disp});
        hour_ones = ones_of({1'b0, hour_disp});
        min_tens  = tens_of(minutes_next);
        min_ones  = ones_of(minutes_next);
`ifdef SECONDS_DISP_EN
        sec_tens  = tens_of(seconds_next);
        sec_ones  = ones_of(seconds_next);
`endif

        colon_seg = SEG_COLON;
        if ((COLON_BLINK != 0) && (prescaler_next >= PRE_HALF)) begin
            colon_seg = SEG_BLANK;
        end

        case (pos_next)
            3'd0:    seg_next = (!mil_time && (hour_tens == 4'd0)) ? SEG_BLANK
                                                                     : seg7(hour_tens);
            3'd1:    seg_next = seg7(hour_ones);
            3'd2:    seg_next = colon_seg;
            3'd3:    seg_next = seg7(min_tens);
            3'd4:    seg_next = seg7(min_ones);
`ifdef SECONDS_DISP_EN
            3'd5:    seg_next = colon_seg;
            3'd6:    seg_next = seg7(sec_tens);
            3'd7:    seg_next = seg7(sec_ones);
`endif
            default: seg_next = SEG_BLANK;
        endcase
    end

    // Display registers: position and its pattern always load together.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt     <= '0;
            digit_select <= 3'd0;
            segment_data <= SEG_BLANK;
        end else begin
            scan_cnt     <= scan_next;
            digit_select <= pos_next;
            segment_data <= seg_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_clock_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_seg_clock_core
//  Description : Self-checking bench for seg_clock_core with a behavioural
//                time/display model and randomized set/run stimulus.
//                Honours SECONDS_DISP_EN to match the design build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_clock_core;

    localparam int T   = 4;
    localparam int TPD = 2;
    localparam int SH  = 0;
`ifdef SECONDS_DISP_EN
    localparam int NPOS = 8;
`else
    localparam int NPOS = 5;
`endif
    localparam logic [6:0] BLANK = 7'b111_1111;
    localparam logic [6:0] COLON = 7'b111_1001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       mil_time = 1'b1;
    logic       inc_hr = 1'b0;
    logic       inc_min = 1'b0;
    logic [6:0] segment_data;
    logic [2:0] digit_select;
    logic       pm;
    logic       sec_tick;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;

    int errors = 0;
    int checks = 0;

    logic [6:0] dig [10] = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
                             7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
                             7'b000_0000, 7'b000_0100};

    seg_clock_core #(
        .TICKS_PER_SEC  (T),
        .TICKS_PER_DIGIT(TPD),
        .START_HOUR     (SH),
        .COLON_BLINK    (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .mil_time    (mil_time),
        .inc_hr      (inc_hr),
        .inc_min     (inc_min),
        .segment_data(segment_data),
        .digit_select(digit_select),
        .pm          (pm),
        .sec_tick    (sec_tick),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds)
    );

    always #5 clk = ~clk;

    // Reference model: clock-of-day fields, count of run cycles and edges.
    int m_h = SH, m_m = 0, m_s = 0, m_pre = 0, m_k = 0;
    bit m_tick = 1'b0, m_mil = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_h <= SH; m_m <= 0; m_s <= 0; m_pre <= 0; m_k <= 0; m_tick <= 1'b0;
        end else begin
            if (m_tick) m_s <= (m_s + 1) % 60;
            if (inc_min || (m_tick && m_s == 59)) m_m <= (m_m + 1) % 60;
            if (inc_hr || (m_tick && m_s == 59 && m_m == 59 && !inc_min))
                m_h <= (m_h + 1) % 24;
            m_tick <= run && (m_pre == T - 1);
            if (run) m_pre <= (m_pre + 1) % T;
            m_k   <= m_k + 1;
            m_mil <= mil_time;
        end
    end

    function automatic int exp_pos();
        return (m_k / TPD) % NPOS;
    endfunction

    function automatic logic [6:0] exp_seg(input int pos);
        int hd;
        if (m_k == 0) return BLANK;
        hd = m_mil ? m_h : ((m_h % 12 == 0) ? 12 : m_h % 12);
        case (pos)
            0:       return (!m_mil && hd < 10) ? BLANK : dig[hd / 10];
            1:       return dig[hd % 10];
            2, 5:    return (m_pre >= T / 2) ? BLANK : COLON;
            3:       return dig[m_m / 10];
            4:       return dig[m_m % 10];
            6:       return dig[m_s / 10];
            7:       return dig[m_s % 10];
            default: return BLANK;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic freeze();
        run = 1'b0;
        step();
        step();
    endtask

    task automatic set_hours(input int h);
        for (int i = 0; i < 30 && m_h != h; i++) begin
            inc_hr = 1'b1; step(); inc_hr = 1'b0;
        end
    endtask

    task automatic set_minutes(input int m);
        for (int i = 0; i < 70 && m_m != m; i++) begin
            inc_min = 1'b1; step(); inc_min = 1'b0;
        end
    endtask

    task automatic capture(input int pa, input int pb,
                           output logic [6:0] sa, output logic [6:0] sb);
        sa = 'x;
        sb = 'x;
        repeat (NPOS * TPD + 1) step();
        for (int i = 0; i < NPOS * TPD; i++) begin
            step();
            if (digit_select == 3'(pa)) sa = segment_data;
            if (digit_select == 3'(pb)) sb = segment_data;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; mil_time = 1'b1;
        repeat (3) step();
        checks++; if (segment_data !== BLANK) begin errors++; $display("FAIL reset_seg: got %b expected %b", segment_data, BLANK); end
        checks++; if (digit_select !== 3'd0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", digit_select); end
        checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", sec_tick); end
        checks++; if (hours !== 5'(SH) || minutes !== 6'd0 || seconds !== 6'd0) begin errors++; $display("FAIL reset_time: got %0d:%0d:%0d expected %0d:0:0", hours, minutes, seconds, SH); end
        checks++; if (pm !== 1'b0) begin errors++; $display("FAIL reset_pm: got %b expected 0", pm); end
        reset = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            checks++; if (sec_tick !== 1'((n % T) == 0)) begin errors++; $display("FAIL first_tick: cycle %0d got %b expected %b", n, sec_tick, (n % T) == 0); end
            checks++; if (seconds !== 6'(m_s)) begin errors++; $display("FAIL tick_seconds: cycle %0d got %0d expected %0d", n, seconds, m_s); end
        end
    endtask

    task automatic test_rollover();
        bit done;
        freeze();
        set_hours(23);
        set_minutes(59);
        checks++; if (hours !== 5'd23 || minutes !== 6'd59 || pm !== 1'b1) begin errors++; $display("FAIL set_2359: got %0d:%0d pm=%b expected 23:59 pm=1", hours, minutes, pm); end
        run = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            if (hours !== 5'd23) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL rollover_timeout: hours got %0d expected 0 within 300 cycles", hours); end
        checks++; if (hours !== 5'd0 || minutes !== 6'd0 || seconds !== 6'd0) begin errors++; $display("FAIL rollover: got %0d:%0d:%0d expected 0:0:0", hours, minutes, seconds); end
        checks++; if (pm !== 1'b0) begin errors++; $display("FAIL rollover_pm: got %b expected 0", pm); end
    endtask

    task automatic test_12h();
        logic [6:0] s0, s1;
        freeze();
        set_hours(0);
        mil_time = 1'b0;
        capture(0, 1, s0, s1);
        checks++; if (s0 !== 7'b100_1111 || s1 !== 7'b001_0010) begin errors++; $display("FAIL h12_midnight: got %b %b expected 1001111 0010010", s0, s1); end
        checks++; if (pm !== 1'b0) begin errors++; $display("FAIL h12_pm0: got %b expected 0", pm); end
        set_hours(13);
        capture(0, 1, s0, s1);
        checks++; if (s0 !== BLANK || s1 !== 7'b100_1111) begin errors++; $display("FAIL h12_13: got %b %b expected 1111111 1001111", s0, s1); end
        checks++; if (pm !== 1'b1) begin errors++; $display("FAIL h12_pm1: got %b expected 1", pm); end
        mil_time = 1'b1;
        capture(0, 1, s0, s1);
        checks++; if (s0 !== 7'b100_1111 || s1 !== 7'b000_0110) begin errors++; $display("FAIL h24_13: got %b %b expected 1001111 0000110", s0, s1); end
    endtask

    task automatic test_collision();
        bit hit;
        run = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step();
            if (m_s == 58) hit = 1'b1;
        end
        freeze();
        set_minutes(5);
        run = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (m_tick && m_s == 59) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL collide_timeout: seconds got %0d expected 59 with tick", seconds); end
        inc_min = 1'b1; step(); inc_min = 1'b0;
        checks++; if (minutes !== 6'd6 || seconds !== 6'd0) begin errors++; $display("FAIL collide: got min=%0d sec=%0d expected min=6 sec=0", minutes, seconds); end
        freeze();
        set_hours(7);
        set_minutes(59);
        inc_min = 1'b1; step(); inc_min = 1'b0;
        checks++; if (minutes !== 6'd0 || hours !== 5'd7) begin errors++; $display("FAIL incmin_wrap: got %0d:%0d expected 7:0", hours, minutes); end
    endtask

    task automatic test_scan_blink();
        run = 1'b1;
        for (int i = 0; i < 48; i++) begin
            step();
            checks++; if (digit_select !== 3'(exp_pos())) begin errors++; $display("FAIL scan_pos: got %0d expected %0d", digit_select, exp_pos()); end
            checks++; if (segment_data !== exp_seg(exp_pos())) begin errors++; $display("FAIL scan_seg: pos %0d got %b expected %b", exp_pos(), segment_data, exp_seg(exp_pos())); end
        end
    endtask

    task automatic test_run_stop();
        int h0, mn0, s0;
        run = 1'b1;
        repeat (5) step();
        run = 1'b0;
        step();
        h0 = m_h; mn0 = m_m; s0 = m_s;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL stop_tick: got %b expected 0", sec_tick); end
        end
        checks++; if (hours !== 5'(h0) || minutes !== 6'(mn0) || seconds !== 6'(s0)) begin errors++; $display("FAIL stop_frozen: got %0d:%0d:%0d expected %0d:%0d:%0d", hours, minutes, seconds, h0, mn0, s0); end
        inc_hr = 1'b1; step(); inc_hr = 1'b0;
        checks++; if (hours !== 5'((h0 + 1) % 24) || minutes !== 6'(mn0)) begin errors++; $display("FAIL stop_inchr: got %0d:%0d expected %0d:%0d", hours, minutes, (h0 + 1) % 24, mn0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            run      = ($urandom_range(0, 3) != 0);
            inc_hr   = ($urandom_range(0, 15) == 0);
            inc_min  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) mil_time = ~mil_time;
            step();
            checks++; if (hours !== 5'(m_h) || minutes !== 6'(m_m) || seconds !== 6'(m_s)) begin errors++; $display("FAIL rnd_time: got %0d:%0d:%0d expected %0d:%0d:%0d", hours, minutes, seconds, m_h, m_m, m_s); end
            checks++; if (sec_tick !== m_tick || pm !== (m_h >= 12)) begin errors++; $display("FAIL rnd_flags: got tick=%b pm=%b expected tick=%b pm=%b", sec_tick, pm, m_tick, m_h >= 12); end
            checks++; if (digit_select !== 3'(exp_pos()) || segment_data !== exp_seg(exp_pos())) begin errors++; $display("FAIL rnd_disp: got %0d/%b expected %0d/%b", digit_select, segment_data, exp_pos(), exp_seg(exp_pos())); end
        end
        inc_hr = 1'b0; inc_min = 1'b0; mil_time = 1'b1;
    endtask

    task automatic test_mid_reset();
        bit hit;
        logic [6:0] sa, sb;
        run = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step();
            if (m_tick && m_s == 13) hit = 1'b1;
        end
        run = 1'b0;
        step();
        set_hours(10);
        set_minutes(30);
        run = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (m_tick) hit = 1'b1; else step();
        end
        run = 1'b0;
        step();
        checks++; if (hours !== 5'd10 || minutes !== 6'd30 || seconds !== 6'd15) begin errors++; $display("FAIL preset_103015: got %0d:%0d:%0d expected 10:30:15", hours, minutes, seconds); end
`ifdef SECONDS_DISP_EN
        capture(6, 7, sa, sb);
        checks++; if (sa !== 7'b100_1111 || sb !== 7'b010_0100) begin errors++; $display("FAIL sec_digits: got %b %b expected 1001111 0100100", sa, sb); end
`else
        capture(3, 4, sa, sb);
        checks++; if (sa !== 7'b000_0110 || sb !== 7'b000_0001) begin errors++; $display("FAIL min_digits: got %b %b expected 0000110 0000001", sa, sb); end
`endif
        reset = 1'b1; inc_hr = 1'b1; inc_min = 1'b1; run = 1'b1;
        step();
        inc_hr = 1'b0; inc_min = 1'b0;
        checks++; if (hours !== 5'(SH) || minutes !== 6'd0 || seconds !== 6'd0) begin errors++; $display("FAIL midreset_time: got %0d:%0d:%0d expected %0d:0:0", hours, minutes, seconds, SH); end
        checks++; if (digit_select !== 3'd0 || segment_data !== BLANK || sec_tick !== 1'b0) begin errors++; $display("FAIL midreset_disp: got %0d/%b/%b expected 0/1111111/0", digit_select, segment_data, sec_tick); end
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_12h();
        test_collision();
        test_scan_blink();
        test_run_stop();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
